target_tracker: RTL

//   Parametrised successor to the fixed 4-target marker wrapper. Takes the per-frame detection

---
 rtl/target_tracker_pkg.sv | 25 ++
 rtl/target_match_dist.sv | 26 ++
 rtl/target_tracker.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/target_tracker_pkg.sv
// Shared types and width helpers for the multi-target tracker.
package target_tracker_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLatch,
    StMatch,
    StSpawn,
    StPublish
  } tt_state_e;

  function automatic int unsigned calc_xw(input int unsigned width);
    return $clog2(width);
  endfunction

  function automatic int unsigned calc_yw(input int unsigned height);
    return $clog2(height) + 1;
  endfunction

  // Index width that never collapses to zero bits.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/target_match_dist.sv
// Manhattan distance between a track and a detection, plus the match-window compare.
module target_match_dist #(
  parameter int unsigned XW         = 11,
  parameter int unsigned YW         = 11,
  parameter int unsigned DW         = 12,
  parameter int unsigned MATCH_DIST = 32
) (
  input  logic [XW-1:0] ax_i,
  input  logic [YW-1:0] ay_i,
  input  logic [XW-1:0] bx_i,
  input  logic [YW-1:0] by_i,
  output logic [DW-1:0] dist_o,
  output logic          in_range_o
);

  logic [XW-1:0] adx;
  logic [YW-1:0] ady;

  always_comb begin
    adx        = (ax_i >= bx_i) ? (ax_i - bx_i) : (bx_i - ax_i);
    ady        = (ay_i >= by_i) ? (ay_i - by_i) : (by_i - ay_i);
    dist_o     = DW'(adx) + DW'(ady);
    in_range_o = (dist_o <= DW'(MATCH_DIST));
  end

endmodule

// File: rtl/target_tracker.sv
// Frame-synchronous tracker: matches detections to slots, smooths, holds lost tracks, publishes.
module target_tracker
  import target_tracker_pkg::*;
#(
  parameter int unsigned NUM_TARGETS   = 4,
  parameter int unsigned SCREEN_WIDTH  = 1280,
  parameter int unsigned SCREEN_HEIGHT = 720,
  parameter int unsigned MATCH_DIST    = 32,
  parameter int unsigned MISS_LIMIT    = 2,
  parameter int unsigned ALPHA_SHIFT   = 1
) (
  input  logic                                         clk_in,
  input  logic                                         rst_in,
  input  logic                                         frame_end_in,
  input  logic [NUM_TARGETS*calc_xw(SCREEN_WIDTH)-1:0]  det_x_in,
  input  logic [NUM_TARGETS*calc_yw(SCREEN_HEIGHT)-1:0] det_y_in,
  input  logic [NUM_TARGETS*calc_yw(SCREEN_HEIGHT)-1:0] det_d_in,
  input  logic [NUM_TARGETS-1:0]                        det_valid_in,
  output logic [NUM_TARGETS*calc_xw(SCREEN_WIDTH)-1:0]  x_out,
  output logic [NUM_TARGETS*calc_yw(SCREEN_HEIGHT)-1:0] y_out,
  output logic [NUM_TARGETS*calc_yw(SCREEN_HEIGHT)-1:0] d_out,
  output logic [NUM_TARGETS-1:0]                        valid_out,
  output logic                                         update_done_out,
  output logic                                         busy_out,
  output logic                                         frame_drop_out
);

  localparam int unsigned N  = NUM_TARGETS;
  localparam int unsigned XW = calc_xw(SCREEN_WIDTH);
  localparam int unsigned YW = calc_yw(SCREEN_HEIGHT);
  localparam int unsigned DW = ((XW > YW) ? XW : YW) + 1;
  localparam int unsigned IW = idx_w(N);
  localparam int unsigned MW = idx_w(MISS_LIMIT + 1);

  typedef struct packed {
    logic          active;
    logic [MW-1:0] miss;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [YW-1:0] d;
  } track_t;

  function automatic logic [XW-1:0] smooth_x(input logic [XW-1:0] v, input logic [XW-1:0] det);
    logic signed [XW:0] diff;
    logic signed [XW:0] sum;
    diff = $signed({1'b0, det}) - $signed({1'b0, v});
    sum  = $signed({1'b0, v}) + (diff >>> ALPHA_SHIFT);
    return sum[XW-1:0];
  endfunction

  function automatic logic [YW-1:0] smooth_y(input logic [YW-1:0] v, input logic [YW-1:0] det);
    logic signed [YW:0] diff;
    logic signed [YW:0] sum;
    diff = $signed({1'b0, det}) - $signed({1'b0, v});
    sum  = $signed({1'b0, v}) + (diff >>> ALPHA_SHIFT);
    return sum[YW-1:0];
  endfunction

  tt_state_e     state_q, state_d;
  track_t        trk_q [N];
  track_t        trk_d [N];
  logic [XW-1:0] dx_q [N];
  logic [YW-1:0] dy_q [N];
  logic [YW-1:0] dd_q [N];
  logic [N-1:0]  dv_q;
  logic [N-1:0]  claimed_q, claimed_d;
  logic          best_valid_q, best_valid_d;
  logic [IW-1:0] best_idx_q, best_idx_d;
  logic [DW-1:0] best_dist_q, best_dist_d;
  logic [IW-1:0] t_idx_q, t_idx_d;
  logic [IW-1:0] d_idx_q, d_idx_d;
  logic          done_q, drop_q;

  logic [DW-1:0] dist_w;
  logic          in_range_w;

  // One distance unit, time-shared across every (track, detection) pair.
  target_match_dist #(
    .XW         (XW),
    .YW         (YW),
    .DW         (DW),
    .MATCH_DIST (MATCH_DIST)
  ) u_dist (
    .ax_i       (trk_q[t_idx_q].x),
    .ay_i       (trk_q[t_idx_q].y),
    .bx_i       (dx_q[d_idx_q]),
    .by_i       (dy_q[d_idx_q]),
    .dist_o     (dist_w),
    .in_range_o (in_range_w)
  );

  logic          cand, take, fin_valid, found;
  logic [IW-1:0] fin_idx, free_idx;

  always_comb begin
    state_d      = state_q;
    trk_d        = trk_q;
    claimed_d    = claimed_q;
    best_valid_d = best_valid_q;
    best_idx_d   = best_idx_q;
    best_dist_d  = best_dist_q;
    t_idx_d      = t_idx_q;
    d_idx_d      = d_idx_q;
    cand         = 1'b0;
    take         = 1'b0;
    fin_valid    = 1'b0;
    fin_idx      = '0;
    found        = 1'b0;
    free_idx     = '0;

    unique case (state_q)
      StIdle: begin
        if (frame_end_in) state_d = StLatch;
      end
      StLatch: begin
        claimed_d    = '0;
        best_valid_d = 1'b0;
        t_idx_d      = '0;
        d_idx_d      = '0;
        state_d      = StMatch;
      end
      StMatch: begin
        cand = trk_q[t_idx_q].active && dv_q[d_idx_q] && !claimed_q[d_idx_q] && in_range_w;
        take = cand && (!best_valid_q || (dist_w < best_dist_q));
        if (take) begin
          best_valid_d = 1'b1;
          best_idx_d   = d_idx_q;
          best_dist_d  = dist_w;
        end
        if (d_idx_q == IW'(N - 1)) begin
          fin_valid    = best_valid_q || take;
          fin_idx      = take ? d_idx_q : best_idx_q;
          best_valid_d = 1'b0;
          d_idx_d      = '0;
          if (trk_q[t_idx_q].active) begin
            if (fin_valid) begin
              claimed_d[fin_idx]  = 1'b1;
              trk_d[t_idx_q].miss = '0;
              trk_d[t_idx_q].x    = smooth_x(trk_q[t_idx_q].x, dx_q[fin_idx]);
              trk_d[t_idx_q].y    = smooth_y(trk_q[t_idx_q].y, dy_q[fin_idx]);
              trk_d[t_idx_q].d    = smooth_y(trk_q[t_idx_q].d, dd_q[fin_idx]);
            end else if (trk_q[t_idx_q].miss >= MW'(MISS_LIMIT)) begin
              trk_d[t_idx_q] = '0;
            end else begin
              trk_d[t_idx_q].miss = trk_q[t_idx_q].miss + 1'b1;
            end
          end
          if (t_idx_q == IW'(N - 1)) begin
            t_idx_d = '0;
            state_d = StSpawn;
          end else begin
            t_idx_d = t_idx_q + 1'b1;
          end
        end else begin
          d_idx_d = d_idx_q + 1'b1;
        end
      end
      StSpawn: begin
        for (int i = 0; i < int'(N); i++) begin
          if (!found && !trk_q[i].active) begin
            found    = 1'b1;
            free_idx = IW'(i);
          end
        end
        // Unclaimed detection with no free slot is dropped without notice.
        if (dv_q[d_idx_q] && !claimed_q[d_idx_q] && found) begin
          trk_d[free_idx].active = 1'b1;
          trk_d[free_idx].miss   = '0;
          trk_d[free_idx].x      = dx_q[d_idx_q];
          trk_d[free_idx].y      = dy_q[d_idx_q];
          trk_d[free_idx].d      = dd_q[d_idx_q];
        end
        if (d_idx_q == IW'(N - 1)) begin
          d_idx_d = '0;
          state_d = StPublish;
        end else begin
          d_idx_d = d_idx_q + 1'b1;
        end
      end
      StPublish: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q      <= StIdle;
      trk_q        <= '{default: '0};
      dx_q         <= '{default: '0};
      dy_q         <= '{default: '0};
      dd_q         <= '{default: '0};
      dv_q         <= '0;
      claimed_q    <= '0;
      best_valid_q <= 1'b0;
      best_idx_q   <= '0;
      best_dist_q  <= '0;
      t_idx_q      <= '0;
      d_idx_q      <= '0;
      x_out        <= '0;
      y_out        <= '0;
      d_out        <= '0;
      valid_out    <= '0;
      done_q       <= 1'b0;
      drop_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      trk_q        <= trk_d;
      claimed_q    <= claimed_d;
      best_valid_q <= best_valid_d;
      best_idx_q   <= best_idx_d;
      best_dist_q  <= best_dist_d;
      t_idx_q      <= t_idx_d;
      d_idx_q      <= d_idx_d;
      done_q       <= (state_q == StPublish);
      drop_q       <= frame_end_in && (state_q != StIdle);
      if (state_q == StIdle && frame_end_in) begin
        dv_q <= det_valid_in;
        for (int i = 0; i < int'(N); i++) begin
          dx_q[i] <= det_x_in[i*XW +: XW];
          dy_q[i] <= det_y_in[i*YW +: YW];
          dd_q[i] <= det_d_in[i*YW +: YW];
        end
      end
      if (state_q == StPublish) begin
        for (int i = 0; i < int'(N); i++) begin
          x_out[i*XW +: XW] <= trk_q[i].x;
          y_out[i*YW +: YW] <= trk_q[i].y;
          d_out[i*YW +: YW] <= trk_q[i].d;
          valid_out[i]      <= trk_q[i].active;
        end
      end
    end
  end

  assign update_done_out = done_q;
  assign frame_drop_out  = drop_q;
  assign busy_out        = (state_q != StIdle);

endmodule
